tribuf_istream_ctrl: RTL and testbench
======================================

// Module: tribuf_istream_ctrl
// PURPOSE
//  Upstream stage of the triple-buffer write-bus mux. Accepts a complex sample stream (valid/ready).
//  Drives the input-stream write port (wact/wa/wdw_istream) into the bank currently in INPUT_STREAM mode.
//  Owns tribuf_status: rotates PHASE_0->PHASE_1->PHASE_2->PHASE_0 when a bank is full and FFT/DMA are idle.
//  Pulses fft_start/dma_start for the banks that have just taken those roles.
// PARAMETERS
//  FFT_N    10  log2 FFT length; bank depth = 2**(FFT_N-1) words
//  FFT_DW   16  real/imag component width; word = 2*FFT_DW bits
//  PHASE_0   0  status encoding: bank0=istream, bank1=fft, bank2=dma
//  PHASE_1   1  status encoding: bank0=fft, bank1=dma, bank2=istream
//  PHASE_2   2  status encoding: bank0=dma, bank1=istream, bank2=fft
// PORTS
//  clk            in   1          single clock, all logic rising-edge
//  rst            in   1          asynchronous, active-high reset
//  enable         in   1          level; 0 = stop accepting samples (state kept)
//  sact_istream   in   1          sample valid
//  sdw_istream    in   2*FFT_DW   sample {imag,real}
//  s_ready        out  1          enable && state==ST_FILL (combinational); 0 while rst
//  wact_istream   out  1          registered write strobe to mux
//  wa_istream     out  FFT_N-1    registered write address
//  wdw_istream    out  2*FFT_DW   registered write data
//  tribuf_status  out  2          registered phase, PHASE_0..PHASE_2 only
//  fft_start      out  1          1-cycle pulse: FFT bank holds a new frame
//  fft_done       in   1          1-cycle pulse from FFT unit
//  dma_start      out  1          1-cycle pulse: DMA bank holds FFT results
//  dma_done       in   1          1-cycle pulse from DMA unit
//  frame_cnt      out  16         rotations since reset, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: state=ST_FILL, wcnt=0, tribuf_status=PHASE_0, all outputs 0.
//    Flags fft_run, dma_run, fft_valid, dma_valid = 0; frame_cnt=0.
//  Accept = sact_istream && s_ready. Edge k accept -> wact_istream=1, wa_istream=wcnt, wdw_istream=sdw in cycle k+1.
//    wcnt++ on accept. No accept -> wact_istream=0; wa/wdw hold.
//  Last word (wcnt==2**(FFT_N-1)-1) accepted at edge k -> wcnt wraps to 0, state=ST_WAIT.
//    s_ready=0 from cycle k+1.
//  can_rot = (!fft_run || fft_done) && (!dma_run || dma_done), i.e. done counts in the same cycle.
//  ST_WAIT && can_rot at edge e (earliest e=k+1):
//    - the last write has already landed in the old bank at that edge;
//    - tribuf_status advances; frame_cnt++;
//    - dma_valid<=fft_valid; fft_valid<=1; state=ST_START.
//  ST_START, one cycle:
//    - fft_start=1, fft_run<=1;
//    - dma_start=dma_valid, dma_run<=dma_valid;
//    - state=ST_FILL. s_ready returns at cycle e+2.
//  Sequence at startup: first rotation -> fft_start only; every later rotation -> fft_start and dma_start.
//  fft_done/dma_done clear fft_run/dma_run.
//    done while not running: ignored.
//    done on the same edge as a start: the start wins (flag=1).
//  enable low mid-frame: acceptance stops; wcnt, state and flags are preserved, so a partial frame resumes.
//    ST_WAIT->rotation is unaffected by enable.
//  rst mid-operation: immediate return to reset values, partial frame discarded.
//    FFT/DMA units must be reset together.
//  tribuf_status never takes value 3. Phase wrap: PHASE_2->PHASE_0.
// STRUCTURE
//  Package tribuf_pkg:
//    - PHASE_* localparams;
//    - state enum {ST_FILL, ST_WAIT, ST_START} (2 bits);
//    - MODE_* constants shared with the write-bus mux.
//  Flat module, no sub-module: write-address counter, phase register, FSM, run/valid flags.
// TESTING (FFT_N=4, depth 8, FFT_DW=16)
//  T1 reset:
//    rst pulse mid-cycle -> status=PHASE_0, wact=0, starts=0, s_ready=1 once enable=1.
//  T2 first frame:
//    8 back-to-back samples 0x0000_0001..0x0000_0008 -> wa 0..7 with matching data, each 1 cycle after accept;
//    status=PHASE_1 one cycle after the last write; fft_start pulse; no dma_start; frame_cnt=1.
//  T3 backpressure:
//    hold fft_done low for 20 cycles after the 2nd frame -> s_ready=0 and status stays PHASE_1.
//    Pulse fft_done -> rotation to PHASE_2 on that edge; fft_start and dma_start both pulse next cycle.
//  T4 simultaneous done:
//    fft_done and dma_done on the same cycle the bank fills -> rotation at the earliest edge (k+1).
//  T5 enable gap:
//    enable=0 after 3 samples for 10 cycles, sact held high -> no writes during the gap;
//    resumes at wa=3; 8 writes total.
//  T6 wrap:
//    4 frames -> status 0,1,2,0,1 in order; never 3; frame_cnt=4.

Source files
------------

// File: rtl/tribuf_pkg.sv
// Shared definitions for the triple-buffer controller and write-bus mux: phase
// encodings, bank modes and the input-stream FSM state type.
package tribuf_pkg;

  localparam logic [1:0] PHASE_0 = 2'd0;
  localparam logic [1:0] PHASE_1 = 2'd1;
  localparam logic [1:0] PHASE_2 = 2'd2;

  localparam logic [1:0] MODE_ISTREAM = 2'd0;
  localparam logic [1:0] MODE_FFT     = 2'd1;
  localparam logic [1:0] MODE_DMA     = 2'd2;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_WAIT,
    ST_START
  } state_e;

  function automatic logic [1:0] next_phase(input logic [1:0] phase);
    unique case (phase)
      PHASE_0: next_phase = PHASE_1;
      PHASE_1: next_phase = PHASE_2;
      default: next_phase = PHASE_0;
    endcase
  endfunction

  // Role of a bank in a given phase: mode = (bank + phase) mod 3.
  function automatic logic [1:0] bank_mode(input logic [1:0] phase, input logic [1:0] bank);
    logic [2:0] sum;
    sum = {1'b0, phase} + {1'b0, bank};
    bank_mode = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
  endfunction

endpackage

// File: rtl/tribuf_istream_ctrl_if.sv
// Sample-stream handshake plus the registered input-stream write port to the mux.
interface tribuf_istream_ctrl_if #(
  parameter int unsigned FFT_N  = 10,
  parameter int unsigned FFT_DW = 16
);
  logic                  sact_istream;
  logic [2*FFT_DW-1:0]   sdw_istream;
  logic                  s_ready;
  logic                  wact_istream;
  logic [FFT_N-2:0]      wa_istream;
  logic [2*FFT_DW-1:0]   wdw_istream;

  modport master (
    output sact_istream, sdw_istream,
    input  s_ready, wact_istream, wa_istream, wdw_istream
  );

  modport slave (
    input  sact_istream, sdw_istream,
    output s_ready, wact_istream, wa_istream, wdw_istream
  );
endinterface

// File: rtl/tribuf_istream_ctrl.sv
// Input-stream stage of the triple buffer: fills the istream bank, rotates the
// bank roles once the bank is full and FFT/DMA are idle, and kicks off FFT/DMA.
module tribuf_istream_ctrl
  import tribuf_pkg::*;
#(
  parameter int unsigned FFT_N  = 10,
  parameter int unsigned FFT_DW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  tribuf_istream_ctrl_if.slave bus,
  output logic [1:0]           tribuf_status,
  output logic                 fft_start,
  input  logic                 fft_done,
  output logic                 dma_start,
  input  logic                 dma_done,
  output logic [15:0]          frame_cnt
);

  localparam int unsigned AW = FFT_N - 1;
  localparam logic [AW-1:0] LastAddr = '1;

  state_e        state;
  logic [AW-1:0] wcnt;
  logic          fft_run, dma_run, fft_valid, dma_valid;
  logic          accept, can_rot;

  assign bus.s_ready = enable && (state == ST_FILL) && !rst;
  assign accept      = bus.sact_istream && bus.s_ready;
  // A done arriving this cycle already frees its unit for the rotation.
  assign can_rot     = (!fft_run || fft_done) && (!dma_run || dma_done);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_FILL;
      wcnt             <= '0;
      tribuf_status    <= PHASE_0;
      frame_cnt        <= '0;
      fft_start        <= 1'b0;
      dma_start        <= 1'b0;
      fft_run          <= 1'b0;
      dma_run          <= 1'b0;
      fft_valid        <= 1'b0;
      dma_valid        <= 1'b0;
      bus.wact_istream <= 1'b0;
      bus.wa_istream   <= '0;
      bus.wdw_istream  <= '0;
    end else begin
      bus.wact_istream <= 1'b0;
      fft_start        <= 1'b0;
      dma_start        <= 1'b0;
      if (fft_done) fft_run <= 1'b0;
      if (dma_done) dma_run <= 1'b0;

      unique case (state)
        ST_FILL: begin
          if (accept) begin
            bus.wact_istream <= 1'b1;
            bus.wa_istream   <= wcnt;
            bus.wdw_istream  <= bus.sdw_istream;
            wcnt             <= wcnt + AW'(1);
            if (wcnt == LastAddr) state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (can_rot) begin
            tribuf_status <= next_phase(tribuf_status);
            frame_cnt     <= frame_cnt + 16'd1;
            dma_valid     <= fft_valid;
            fft_valid     <= 1'b1;
            fft_start     <= 1'b1;
            dma_start     <= fft_valid;
            state         <= ST_START;
          end
        end
        ST_START: begin
          // Set after the done-clear above so a same-edge done loses to the start.
          fft_run <= 1'b1;
          dma_run <= dma_valid;
          state   <= ST_FILL;
        end
        default: state <= ST_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_tribuf_istream_ctrl.sv
// Randomized bench for tribuf_istream_ctrl: a frame-level model predicts every
// output each cycle from the accept/rotate rules of the triple buffer.
module tb_tribuf_istream_ctrl;

  localparam int unsigned FFT_N  = 4;
  localparam int unsigned FFT_DW = 16;
  localparam int          DEPTH  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        fft_done = 1'b0;
  logic        dma_done = 1'b0;
  logic [1:0]  tribuf_status;
  logic        fft_start, dma_start;
  logic [15:0] frame_cnt;

  tribuf_istream_ctrl_if #(.FFT_N(FFT_N), .FFT_DW(FFT_DW)) bus ();

  tribuf_istream_ctrl #(.FFT_N(FFT_N), .FFT_DW(FFT_DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .bus           (bus),
    .tribuf_status (tribuf_status),
    .fft_start     (fft_start),
    .fft_done      (fft_done),
    .dma_start     (dma_start),
    .dma_done      (dma_done),
    .frame_cnt     (frame_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: words in the current frame, unit busy flags, frame count.
  int          m_words;
  bit          m_fft_busy, m_dma_busy, m_had_frame;
  bit          m_wact;
  int          m_wa;
  logic [31:0] m_wdw;
  int          m_phase;
  bit          m_fft_start, m_dma_start;
  logic [15:0] m_frames;

  task automatic model_reset();
    m_words = 0; m_fft_busy = 0; m_dma_busy = 0; m_had_frame = 0;
    m_wact = 0; m_wa = 0; m_wdw = '0; m_phase = 0;
    m_fft_start = 0; m_dma_start = 0; m_frames = '0;
  endtask

  task automatic step(input bit sa, input logic [31:0] d, input bit en, input bit fd,
                      input bit dd);
    bit exp_ready, acc, was_full, can, starting, dma_go;
    @(negedge clk);
    bus.sact_istream = sa;
    bus.sdw_istream  = d;
    enable           = en;
    fft_done         = fd;
    dma_done         = dd;
    #1;
    exp_ready = en && (m_words < DEPTH) && !m_fft_start;
    check_eq("s_ready", bus.s_ready, exp_ready);
    check_eq("wact", bus.wact_istream, m_wact);
    check_eq("wa", bus.wa_istream, m_wa);
    check_eq("wdw", bus.wdw_istream, m_wdw);
    check_eq("status", tribuf_status, m_phase);
    check_eq("fft_start", fft_start, m_fft_start);
    check_eq("dma_start", dma_start, m_dma_start);
    check_eq("frame_cnt", frame_cnt, m_frames);
    acc = sa && exp_ready;
    @(posedge clk);
    was_full = (m_words == DEPTH);
    can      = (!m_fft_busy || fd) && (!m_dma_busy || dd);
    starting = m_fft_start;
    dma_go   = m_dma_start;
    if (starting) begin
      m_fft_busy = 1;
      m_dma_busy = dma_go;
    end else begin
      if (fd) m_fft_busy = 0;
      if (dd) m_dma_busy = 0;
    end
    m_wact = acc;
    if (acc) begin
      m_wa  = m_words;
      m_wdw = d;
      m_words++;
    end
    m_fft_start = 0;
    m_dma_start = 0;
    if (was_full && can) begin
      m_phase     = (m_phase + 1) % 3;
      m_frames    = m_frames + 16'd1;
      m_words     = 0;
      m_fft_start = 1;
      m_dma_start = m_had_frame;
      m_had_frame = 1;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    bus.sact_istream = 1'b0;
    fft_done = 1'b0;
    dma_done = 1'b0;
    enable = 1'b1;
    #2 rst = 1'b1;
    #1;
    check_eq("rst_s_ready", bus.s_ready, 0);
    check_eq("rst_wact", bus.wact_istream, 0);
    check_eq("rst_wa", bus.wa_istream, 0);
    check_eq("rst_status", tribuf_status, 0);
    check_eq("rst_fft_start", fft_start, 0);
    check_eq("rst_dma_start", dma_start, 0);
    check_eq("rst_frame_cnt", frame_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    bus.sact_istream = 1'b0;
    bus.sdw_istream  = '0;
    model_reset();
    apply_reset();

    // First frame: fft_start only.
    for (int i = 1; i <= DEPTH; i++) step(1, 32'(i), 1, 0, 0);
    repeat (4) step(0, 32'h0, 1, 0, 0);

    // Second frame with the FFT held busy, then released.
    for (int i = 0; i < DEPTH; i++) step(1, 32'h100 + 32'(i), 1, 0, 0);
    repeat (20) step(1, $urandom, 1, 0, 0);
    step(1, $urandom, 1, 1, 0);
    repeat (3) step(0, 32'h0, 1, 0, 0);

    // Both dones on the cycle the last word is accepted.
    for (int i = 0; i < DEPTH - 1; i++) step(1, $urandom, 1, 0, 0);
    step(1, $urandom, 1, 1, 1);
    repeat (3) step(0, 32'h0, 1, 0, 0);

    // Enable gap mid-frame with sact held high.
    for (int i = 0; i < 3; i++) step(1, $urandom, 1, 0, 0);
    repeat (10) step(1, $urandom, 0, 0, 0);
    for (int i = 3; i < DEPTH; i++) step(1, $urandom, 1, 0, 0);
    repeat (3) step(0, 32'h0, 1, 1, 1);

    // Random traffic, enable and done pulses.
    repeat (1500)
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 9) != 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);

    // Reset in the middle of activity, then carry on.
    for (int i = 0; i < 5; i++) step(1, $urandom, 1, 0, 0);
    apply_reset();
    repeat (400)
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 9) != 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
